// File: rtl/add3_pkg.sv
// add3_pkg: shared width default, clog2 helper and packed-operand slice for the add3 scheduler.
`define ADD3_SLICE(bus, i, w) bus[(i)*(w) +: (w)]
package add3_pkg;
  localparam int WIDTH_DEF = 16;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v >>= 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, scanning from ptr upward modulo NREQ.
module rr_arbiter import add3_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);
  logic           found;
  logic [IDW-1:0] j;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        gnt_idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/add3_rr_sched.sv
// add3_rr_sched: round-robin sharing of a two-stage (a+b, then +c) adder pipeline between NREQ requesters.
module add3_rr_sched import add3_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*WIDTH-1:0] req_c,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);
  if (NREQ < 2 || IDW != clog2(NREQ)) begin : g_param_check
    $error("add3_rr_sched: need NREQ >= 2 and IDW == clog2(NREQ)");
  end
  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_ab, s1_c, s2_sum;
  logic [IDW-1:0]   s1_id, s2_id, rr_ptr, gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic             advance, s1_free;
  assign advance = !s2_valid || res_ready;
  assign s1_free = !s1_valid || advance;
  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid),
    .en(s1_free && rst_n),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  assign req_ready = gnt;
  assign res_valid = s2_valid;
  assign res_data = s2_sum;
  assign res_id = s2_id;
  assign busy = s1_valid || s2_valid;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ab <= '0;
      s1_c <= '0;
      s1_id <= '0;
      s2_valid <= 1'b0;
      s2_sum <= '0;
      s2_id <= '0;
      rr_ptr <= '0;
    end else begin
      if (advance) begin
        s2_valid <= s1_valid;
        s2_sum <= s1_ab + s1_c;
        s2_id <= s1_id;
      end
      if (s1_free) begin
        s1_valid <= |gnt;
        s1_ab <= `ADD3_SLICE(req_a, gnt_idx, WIDTH) + `ADD3_SLICE(req_b, gnt_idx, WIDTH);
        s1_c <= `ADD3_SLICE(req_c, gnt_idx, WIDTH);
        s1_id <= gnt_idx;
      end
      if (|gnt) rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_add3_rr_sched.sv
// tb_add3_rr_sched: randomized and directed scoreboard bench for add3_rr_sched.
module tb_add3_rr_sched;
  localparam int W = 16;
  localparam int N = 4;
  logic          clock, rst_n, res_ready, res_valid, busy;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic [W-1:0]  res_data;
  logic [1:0]    res_id;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct { logic [W-1:0] d; logic [1:0] id; int e; } item_t;
  item_t q[$];
  int m_ptr = 0;

  add3_rr_sched #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: results leave in acceptance order one edge after entering S1;
  // at most two triples in flight; grant goes to the first valid requester at/after m_ptr.
  always @(negedge clock) begin
    int n, w;
    logic exp_rv, free;
    logic [N-1:0] exp_gnt;
    logic [W-1:0] a, b, c;
    if (!rst_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      q.delete();
      m_ptr = 0;
    end else begin
      n = q.size();
      exp_rv = n > 0 && cyc >= q[0].e + 1;
      chk("res_valid", res_valid, exp_rv);
      chk("busy", busy, n > 0);
      free = n < 2 || res_ready;
      if (exp_rv && res_valid) begin
        chk("res_data", res_data, q[0].d);
        chk("res_id", res_id, q[0].id);
        if (res_ready) void'(q.pop_front());
      end
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_gnt = (free && w >= 0) ? N'(1 << w) : '0;
      chk("req_ready", req_ready, exp_gnt);
      if (exp_gnt != 0) begin
        a = req_a[w*W +: W];
        b = req_b[w*W +: W];
        c = req_c[w*W +: W];
        q.push_back('{d: W'(a + b + c), id: 2'(w), e: cyc + 1});
        m_ptr = (w + 1) % N;
      end
      chk("inflight_le2", q.size() <= 2, 1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rand_ops();
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_c = {$urandom, $urandom};
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  initial begin
    rst_n = 0;
    req_valid = 0;
    req_a = 0;
    req_b = 0;
    req_c = 0;
    res_ready = 1;
    step(3);
    rst_n = 1;
    step(2);
    // single requester 2
    set_op(2, 16'h0003, 16'h0004, 16'h0005);
    req_valid = 4'b0100;
    step(1);
    req_valid = 0;
    step(4);
    // all four requesting, full throughput
    req_valid = 4'b1111;
    repeat (12) begin
      rand_ops();
      step(1);
    end
    req_valid = 0;
    step(4);
    // backpressure then drain
    res_ready = 0;
    req_valid = 4'b1111;
    rand_ops();
    step(5);
    res_ready = 1;
    step(6);
    req_valid = 0;
    step(4);
    // wrap-around
    set_op(0, 16'hFFFF, 16'h0001, 16'hFFFF);
    req_valid = 4'b0001;
    step(1);
    set_op(0, 16'h8000, 16'h8000, 16'h0000);
    step(1);
    req_valid = 0;
    step(4);
    // rotation from rr_ptr=3, late requester 0
    req_valid = 4'b0100;
    rand_ops();
    step(1);
    req_valid = 4'b1010;
    step(2);
    req_valid = 4'b0011;
    step(2);
    req_valid = 0;
    step(4);
    // random traffic with random backpressure
    repeat (400) begin
      req_valid = N'($urandom);
      res_ready = $urandom_range(0, 3) != 0;
      rand_ops();
      step(1);
    end
    // reset mid-stream with both stages full
    res_ready = 0;
    req_valid = 4'b1111;
    step(4);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_res_valid", res_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_req_ready", req_ready, 0);
    req_valid = 0;
    step(2);
    rst_n = 1;
    res_ready = 1;
    step(5);
    // final drain with a bounded wait
    req_valid = 0;
    res_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
    chk("drain_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
